// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared types and helpers for the Montgomery multiplier
package mmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2
    } mmm_state_e;

    // The accumulator carries two guard bits so r_q < 2n plus an addend never overflows
    function automatic int acc_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/montgomery_multiplier_if.sv
// rtl/montgomery_multiplier_if.sv - operand/result handshake bundle for the Montgomery multiplier
interface montgomery_multiplier_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (output start, a, b, n, input busy, done, result, err);
    modport slave  (input start, a, b, n, output busy, done, result, err);
endinterface

// File: rtl/mmm_step.sv
// rtl/mmm_step.sv - one combinational radix-2 Montgomery iteration
module mmm_step
    import mmm_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int ACC_W = acc_width(WIDTH)
) (
    input  logic [ACC_W-1:0] r,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [ACC_W-1:0] r_next
);
    logic [ACC_W-1:0] b_add;
    logic [ACC_W-1:0] n_add;
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] t;

    // Add b when the current multiplier bit is set, then add n to make the sum even
    always_comb begin
        b_add = a_bit ? {2'b00, b} : '0;
        n_add = s[0]  ? {2'b00, n} : '0;
    end

    ripple_carry_adder #(.WIDTH(ACC_W)) u_add_b (
        .a   (r),
        .b   (b_add),
        .cin (1'b0),
        .sum (s)
    );

    ripple_carry_adder #(.WIDTH(ACC_W)) u_add_n (
        .a   (s),
        .b   (n_add),
        .cin (1'b0),
        .sum (t)
    );

    // t is even by construction, so the shift is an exact division by two
    assign r_next = t >> 1;
endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - plain ripple-carry adder, carry-out dropped (callers size it wide enough)
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/montgomery_multiplier.sv
// rtl/montgomery_multiplier.sv - iterative radix-2 Montgomery multiplier; optional MMM_OPERAND_CHECK_EN operand screening
module montgomery_multiplier
    import mmm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    montgomery_multiplier_if.slave bus
);
    localparam int ACC_W = acc_width(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    mmm_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [ACC_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] r_step;
    logic [ACC_W-1:0] diff;

    mmm_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .a_bit  (a_q[0]),
        .b      (b_q),
        .n      (n_q),
        .r_next (r_step)
    );

    // Final conditional subtraction: r_q - n_q as r_q + ~n_q + 1
    ripple_carry_adder #(.WIDTH(ACC_W)) u_sub (
        .a   (r_q),
        .b   (~{2'b00, n_q}),
        .cin (1'b1),
        .sum (diff)
    );

`ifdef MMM_OPERAND_CHECK_EN
    logic err_q, err_d;
    logic bad_operands;

    assign bad_operands = ~bus.n[0] | (bus.a >= bus.n) | (bus.b >= bus.n);
`endif

    // Next-state and datapath control; everything holds unless a state says otherwise
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef MMM_OPERAND_CHECK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef MMM_OPERAND_CHECK_EN
                    if (bad_operands) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        n_d     = bus.n;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
`else
                    a_d     = bus.a;
                    b_d     = bus.b;
                    n_d     = bus.n;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                r_d   = r_step;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                // A set sign bit means r_q < n, so r_q is already reduced
                result_d = WIDTH'(diff[ACC_W-1] ? r_q : diff);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef MMM_OPERAND_CHECK_EN
    // Error flag travels with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
